// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
// Round-robin arbiter that shares one single-beat combinational data bus
// between NUM_REQUESTERS masters. A master may lock the bus for a burst.
// A hold counter bounds each locked tenure to MAX_HOLD granted beats.
//
// Ports
//   clock_i, reset_i       : clock, synchronous active-high reset
//   req_i / lock_i         : per-master beat request / keep-bus-after-beat
//   req_address_i, req_size_i, req_write_i, req_write_data_i : per-master beat fields
//   ack_o                  : per-master beat accepted (same cycle), one-hot or zero
//   req_read_data_o        : read data for the acked master (0 when nothing granted)
//   address_o, size_o, read_enable_o, write_enable_o, write_data_o : shared bus
//   read_data_i            : combinational read data from the decoder
//   busy_o                 : arbiter is holding the bus for a locked owner
//   owner_o                : current or most recently granted master
// Size encoding (mem_size_t): 2 bits, passed through untouched.
module data_bus_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int MAX_HOLD       = 16,
  localparam int IdxW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                             clock_i,
  input  logic                             reset_i,
  input  logic [NUM_REQUESTERS-1:0]        req_i,
  input  logic [NUM_REQUESTERS-1:0]        lock_i,
  input  logic [NUM_REQUESTERS-1:0][31:0]  req_address_i,
  input  logic [NUM_REQUESTERS-1:0][1:0]   req_size_i,
  input  logic [NUM_REQUESTERS-1:0]        req_write_i,
  input  logic [NUM_REQUESTERS-1:0][31:0]  req_write_data_i,
  output logic [NUM_REQUESTERS-1:0]        ack_o,
  output logic [31:0]                      req_read_data_o,
  output logic [31:0]                      address_o,
  output logic [1:0]                       size_o,
  output logic                             read_enable_o,
  output logic                             write_enable_o,
  output logic [31:0]                      write_data_o,
  input  logic [31:0]                      read_data_i,
  output logic                             busy_o,
  output logic [IdxW-1:0]                  owner_o
);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      hold_q, hold_d;

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] cand_idx;
  logic            grant;
  logic [IdxW-1:0] gnt_idx;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] x);
    return (int'(x) == NUM_REQUESTERS - 1) ? '0 : x + 1'b1;
  endfunction

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand_idx = IdxW'((int'(rr_ptr_q) + i) % NUM_REQUESTERS);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    grant    = 1'b0;
    gnt_idx  = owner_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant   = 1'b1;
          gnt_idx = win_idx;
          owner_d = win_idx;
          // A one-beat tenure can never continue, so a lock is treated as a plain beat.
          if (lock_i[win_idx] && MAX_HOLD > 1) begin
            state_d = S_LOCKED;
            hold_d  = 8'd1;
          end else begin
            rr_ptr_d = next_idx(win_idx);
          end
        end
      end
      S_LOCKED: begin
        if (req_i[owner_q]) begin
          grant  = 1'b1;
          hold_d = hold_q + 8'd1;
          // Lock dropped or tenure exhausted: this beat is the last of the burst.
          if (!lock_i[owner_q] || (hold_q + 8'd1) == 8'(MAX_HOLD)) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_idx(owner_q);
          end
        end else if (!lock_i[owner_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_idx(owner_q);
        end
        // Owner idle with lock held: keep the bus, hold count untouched.
      end
    endcase
  end

  always_comb begin
    ack_o           = '0;
    address_o       = '0;
    size_o          = '0;
    read_enable_o   = 1'b0;
    write_enable_o  = 1'b0;
    write_data_o    = '0;
    req_read_data_o = '0;
    if (grant) begin
      ack_o[gnt_idx]  = 1'b1;
      address_o       = req_address_i[gnt_idx];
      size_o          = req_size_i[gnt_idx];
      read_enable_o   = !req_write_i[gnt_idx];
      write_enable_o  = req_write_i[gnt_idx];
      write_data_o    = req_write_data_i[gnt_idx];
      req_read_data_o = read_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
    end
  end

  assign busy_o  = (state_q == S_LOCKED);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter with two masters and MAX_HOLD = 4.
// Each scenario task forks a driver (drives one cycle, pushes the expected
// bus observation) and a checker (pops and compares at the falling edge).
module tb_data_bus_arbiter;

  localparam int N  = 2;
  localparam int MH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req, lock, wr;
  logic [N-1:0][31:0]  addr, wdat;
  logic [N-1:0][1:0]   size;
  logic [N-1:0]        ack;
  logic [31:0]         rrd, bus_addr, bus_wd, rd;
  logic [1:0]          bus_size;
  logic                re, we, busy;
  logic                owner;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        owner;
  } obs_t;

  obs_t sb[$];

  data_bus_arbiter #(.NUM_REQUESTERS(N), .MAX_HOLD(MH)) dut (
    .clock_i(clk), .reset_i(rst), .req_i(req), .lock_i(lock),
    .req_address_i(addr), .req_size_i(size), .req_write_i(wr),
    .req_write_data_i(wdat), .ack_o(ack), .req_read_data_o(rrd),
    .address_o(bus_addr), .size_o(bus_size), .read_enable_o(re),
    .write_enable_o(we), .write_data_o(bus_wd), .read_data_i(rd),
    .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Master 0 always uses size 2, master 1 size 1.
  function automatic obs_t mk(input logic [1:0] a, input logic [31:0] ad, input logic r,
                              input logic w, input logic [31:0] wdv, input logic [31:0] rdv,
                              input logic b, input logic o);
    obs_t e;
    e.ack   = a;
    e.addr  = ad;
    e.size  = (a == 2'b01) ? 2'd2 : (a == 2'b10) ? 2'd1 : 2'd0;
    e.re    = r;
    e.we    = w;
    e.wdata = wdv;
    e.rdata = rdv;
    e.busy  = b;
    e.owner = o;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t g;
    g.ack = ack; g.addr = bus_addr; g.size = bus_size; g.re = re; g.we = we;
    g.wdata = bus_wd; g.rdata = rrd; g.busy = busy; g.owner = owner;
    return g;
  endfunction

  localparam obs_t ZERO_O0 = '0;

  task automatic step(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                      input logic [31:0] a0, input logic [31:0] a1, input logic rs,
                      input logic [31:0] rdv, input obs_t e);
    @(posedge clk); #1;
    req = r; lock = l; wr = w; rst = rs; rd = rdv;
    addr[0] = a0; addr[1] = a1;
    wdat[0] = w[0] ? wd(a0) : 32'h0;
    wdat[1] = w[1] ? wd(a1) : 32'h0;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; lock = '0; wr = '0; rd = '0;
    addr = '0; wdat = '0; size[0] = 2'd2; size[1] = 2'd1;
    @(posedge clk);
    @(posedge clk);
    sb.delete();
  endtask

  task automatic test_reset();
    obs_t g, e;
    fork
      begin
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, ZERO_O0);
        step(2'b00, 2'b00, 2'b00, 32'h44, 32'h88, 1'b0, 32'hFFFF_FFFF, ZERO_O0);
      end
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL reset c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL reset c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  task automatic test_single();
    obs_t g, e;
    fork
      begin
        step(2'b01, 2'b00, 2'b00, 32'h1000, 32'h0, 1'b0, 32'hCAFE_0001,
             mk(2'b01, 32'h1000, 1'b1, 1'b0, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0));
        // rr_ptr moved to 1, so master 1 wins a tie.
        step(2'b11, 2'b00, 2'b00, 32'h1000, 32'h3000, 1'b0, 32'hCAFE_0002,
             mk(2'b10, 32'h3000, 1'b1, 1'b0, 32'h0, 32'hCAFE_0002, 1'b0, 1'b0));
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
             mk(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
      end
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL single c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL single c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  task automatic test_contention();
    obs_t g, e;
    fork
      for (int k = 0; k < 6; k++)
        step(2'b11, 2'b00, 2'b00, 32'h100, 32'h200, 1'b0, 32'h0,
             mk(k[0] ? 2'b10 : 2'b01, k[0] ? 32'h200 : 32'h100, 1'b1, 1'b0, 32'h0, 32'h0,
                1'b0, (k == 0) ? 1'b0 : !k[0]));
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL contention c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL contention c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  task automatic test_locked_burst();
    obs_t g, e;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          logic [31:0] a;
          a = 32'h2000 + 32'(4 * k);
          step(2'b11, {1'b0, (k < 3)}, 2'b01, a, 32'h300, 1'b0, 32'h0,
               mk(2'b01, a, 1'b0, 1'b1, wd(a), 32'h0, (k > 0), 1'b0));
        end
        step(2'b10, 2'b00, 2'b00, 32'h0, 32'h300, 1'b0, 32'h0,
             mk(2'b10, 32'h300, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
             mk(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
      end
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL burst c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL burst c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  // Lock dropped after 2 beats, well short of MAX_HOLD.
  task automatic test_lock_drop();
    obs_t g, e;
    fork
      begin
        step(2'b11, 2'b01, 2'b00, 32'h5000, 32'h500, 1'b0, 32'h0,
             mk(2'b01, 32'h5000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        step(2'b11, 2'b00, 2'b00, 32'h5004, 32'h500, 1'b0, 32'h0,
             mk(2'b01, 32'h5004, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
        step(2'b11, 2'b00, 2'b00, 32'h5008, 32'h500, 1'b0, 32'h0,
             mk(2'b10, 32'h500, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
             mk(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
      end
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL lockdrop c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL lockdrop c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  task automatic test_forced_release();
    obs_t g, e;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          logic [31:0] a;
          a = 32'h8000 + 32'(4 * k);
          step(2'b11, 2'b01, 2'b00, a, 32'h900, 1'b0, 32'h0,
               (k < MH) ? mk(2'b01, a, 1'b1, 1'b0, 32'h0, 32'h0, (k > 0), 1'b0)
                        : mk(2'b10, 32'h900, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        end
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
             mk(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
      end
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL forced c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL forced c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  // 1 beat, 3 idle slots with lock held, then 3 more beats until the hold limit.
  task automatic test_idle_slot();
    obs_t g, e;
    fork
      begin
        step(2'b11, 2'b01, 2'b01, 32'h4000, 32'hA00, 1'b0, 32'h0,
             mk(2'b01, 32'h4000, 1'b0, 1'b1, wd(32'h4000), 32'h0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
          step(2'b10, 2'b01, 2'b01, 32'h4004, 32'hA00, 1'b0, 32'h0,
               mk(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
          logic [31:0] a;
          a = 32'h4004 + 32'(4 * k);
          step(2'b11, 2'b01, 2'b01, a, 32'hA00, 1'b0, 32'h0,
               mk(2'b01, a, 1'b0, 1'b1, wd(a), 32'h0, 1'b1, 1'b0));
        end
        step(2'b11, 2'b01, 2'b01, 32'h4010, 32'hA00, 1'b0, 32'h0,
             mk(2'b10, 32'hA00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
             mk(2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
      end
      for (int k = 0; k < 9; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL idleslot c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL idleslot c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  // Master 1 locks after master 0 moved rr_ptr to 1; reset lands on beat 2.
  task automatic test_reset_burst();
    obs_t g, e;
    fork
      begin
        step(2'b01, 2'b00, 2'b00, 32'h6000, 32'h0, 1'b0, 32'h0,
             mk(2'b01, 32'h6000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        step(2'b10, 2'b10, 2'b10, 32'h0, 32'h7000, 1'b0, 32'h0,
             mk(2'b10, 32'h7000, 1'b0, 1'b1, wd(32'h7000), 32'h0, 1'b0, 1'b0));
        step(2'b10, 2'b10, 2'b10, 32'h0, 32'h7004, 1'b1, 32'h0,
             mk(2'b10, 32'h7004, 1'b0, 1'b1, wd(32'h7004), 32'h0, 1'b1, 1'b1));
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, ZERO_O0);
        step(2'b11, 2'b00, 2'b00, 32'h6100, 32'h7100, 1'b0, 32'h0,
             mk(2'b01, 32'h6100, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0));
        step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, ZERO_O0);
      end
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); @(negedge clk);
        tests++;
        if (sb.size() == 0) begin failed++; $display("FAIL rstburst c%0d: no expected entry", k); end
        else begin
          e = sb.pop_front(); g = sample();
          if (g !== e) begin failed++; $display("FAIL rstburst c%0d: got %h required %h", k, g, e); end
        end
      end
    join
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; wr = '0; rd = '0;
    addr = '0; wdat = '0; size = '0;
    do_reset(); test_reset();
    do_reset(); test_single();
    do_reset(); test_contention();
    do_reset(); test_locked_burst();
    do_reset(); test_lock_drop();
    do_reset(); test_forced_release();
    do_reset(); test_idle_slot();
    do_reset(); test_reset_burst();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
